// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Purpose:
//   AMBA 3 APB bus master. It bridges a simple request interface onto an APB
//   bus with up to two slave selects:
//     - transfer strobe
//     - read/write select
//     - separate read and write addresses
//     - write data
//   It runs the IDLE -> SETUP -> ACCESS protocol, honours PREADY wait states
//   and keeps the data from the last completed read.
//
// Configuration macro:
//   APB_MASTER_SEL2_EN
//     defined   : PADDR[ADDRESS_WIDTH-1] chooses between PSEL1 (0) and
//                 PSEL2 (1).
//     undefined : every transfer goes to PSEL1 and PSEL2 is tied to 0.
//                 PADDR still carries the full address.
//
// Ports:
//   PCLK               in   bus clock; every state change is on its
//                           rising edge
//   PRESETn            in   asynchronous reset, active HIGH despite the name
//   transfer           in   request strobe; high = start or continue
//                           transfers
//   READ_WRITE         in   1 = read, 0 = write; sampled with transfer
//   PREADY             in   slave ready; ends the ACCESS phase
//   apb_write_paddr    in   write target address
//   apb_write_data     in   write data
//   apb_read_paddr     in   read target address
//   PRDATA             in   slave read data
//   PWRITE             out  APB direction, 1 = write
//   PENABLE            out  APB enable (ACCESS phase)
//   PSEL1              out  select for slave 1
//   PSEL2              out  select for slave 2
//   PADDR              out  APB address
//   PWDATA             out  APB write data
//   apb_read_data_out  out  data from the last completed read
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     transfer,
    input  logic                     READ_WRITE,
    input  logic                     PREADY,
    input  logic [ADDRESS_WIDTH-1:0] apb_write_paddr,
    input  logic [DATA_WIDTH-1:0]    apb_write_data,
    input  logic [ADDRESS_WIDTH-1:0] apb_read_paddr,
    input  logic [DATA_WIDTH-1:0]    PRDATA,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic                     PSEL1,
    output logic                     PSEL2,
    output logic [ADDRESS_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0]    PWDATA,
    output logic [DATA_WIDTH-1:0]    apb_read_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     pwrite_q;
    logic [ADDRESS_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0]    pwdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;

    // A new request is latched on every edge that moves the FSM into SETUP.
    // That happens either from IDLE, or from a completing ACCESS while
    // transfer is still high (back-to-back transfers).
    logic enter_setup;
    // A transfer completes when ACCESS sees PREADY high.
    logic complete;
    // Slave decode comes only from the latched address, so the selects never
    // depend combinationally on the request inputs.
    logic sel2_hit;

    assign complete    = (state_q == ST_ACCESS) && PREADY;
    assign enter_setup = (state_d == ST_SETUP);

`ifdef APB_MASTER_SEL2_EN
    assign sel2_hit = paddr_q[ADDRESS_WIDTH-1];
`else
    assign sel2_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d = transfer ? ST_SETUP : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: depends only on registered state and address
    // ------------------------------------------------------------------
    always_comb begin
        PENABLE = 1'b0;
        PSEL1   = 1'b0;
        PSEL2   = 1'b0;
        case (state_q)
            ST_SETUP: begin
                PSEL1 = ~sel2_hit;
                PSEL2 = sel2_hit;
            end
            ST_ACCESS: begin
                PENABLE = 1'b1;
                PSEL1   = ~sel2_hit;
                PSEL2   = sel2_hit;
            end
            default: begin
                PENABLE = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    // The latched fields stay stable through SETUP and through every ACCESS
    // wait state. A read leaves PWDATA at its previous value.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (enter_setup) begin
            pwrite_q <= ~READ_WRITE;
            paddr_q  <= READ_WRITE ? apb_read_paddr : apb_write_paddr;
            if (!READ_WRITE) begin
                pwdata_q <= apb_write_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data capture
    // ------------------------------------------------------------------
    // Only a completing read updates the captured data; writes leave it as
    // it was.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            rdata_q <= '0;
        end else if (complete && !pwrite_q) begin
            rdata_q <= PRDATA;
        end
    end

    assign PWRITE            = pwrite_q;
    assign PADDR             = paddr_q;
    assign PWDATA            = pwdata_q;
    assign apb_read_data_out = rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Table-driven bench for apb_master.
//   - Each vector drives one clock cycle of inputs and lists the outputs
//     expected after that cycle's rising edge.
//   - Hand-written sequences cover reset and the asynchronous abort.
// ---------------------------------------------------------------------------
module tb_apb_master;

    localparam int DW = 32;
    localparam int AW = 32;

`ifdef APB_MASTER_SEL2_EN
    localparam bit SEL2 = 1'b1;
`else
    localparam bit SEL2 = 1'b0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          transfer;
    logic          READ_WRITE;
    logic          PREADY;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] PRDATA;
    logic          PWRITE;
    logic          PENABLE;
    logic          PSEL1;
    logic          PSEL2;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] apb_read_data_out;

    apb_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .PREADY            (PREADY),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .PRDATA            (PRDATA),
        .PWRITE            (PWRITE),
        .PENABLE           (PENABLE),
        .PSEL1             (PSEL1),
        .PSEL2             (PSEL2),
        .PADDR             (PADDR),
        .PWDATA            (PWDATA),
        .apb_read_data_out (apb_read_data_out)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic          pwrite;
        logic          penable;
        logic          psel1;
        logic          psel2;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwdata;
        logic [DW-1:0] rdata;
    } out_t;

    typedef struct packed {
        logic          tr;
        logic          rw;
        logic          rdy;
        logic [AW-1:0] wpa;
        logic [DW-1:0] wd;
        logic [AW-1:0] rpa;
        logic [DW-1:0] prd;
        out_t          exp;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    function automatic out_t mko(
        input logic          pw,
        input logic          pen,
        input logic          s1,
        input logic          s2,
        input logic [AW-1:0] pa,
        input logic [DW-1:0] pwd,
        input logic [DW-1:0] rd
    );
        out_t o;
        o.pwrite  = pw;
        o.penable = pen;
        o.psel1   = s1;
        o.psel2   = s2;
        o.paddr   = pa;
        o.pwdata  = pwd;
        o.rdata   = rd;
        return o;
    endfunction

    function automatic vec_t mkv(
        input logic          tr,
        input logic          rw,
        input logic          rdy,
        input logic [AW-1:0] wpa,
        input logic [DW-1:0] wd,
        input logic [AW-1:0] rpa,
        input logic [DW-1:0] prd,
        input out_t          exp
    );
        vec_t v;
        v.tr  = tr;
        v.rw  = rw;
        v.rdy = rdy;
        v.wpa = wpa;
        v.wd  = wd;
        v.rpa = rpa;
        v.prd = prd;
        v.exp = exp;
        return v;
    endfunction

    function automatic out_t sample();
        return mko(PWRITE, PENABLE, PSEL1, PSEL2, PADDR, PWDATA,
                   apb_read_data_out);
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pw=%b en=%b s1=%b s2=%b addr=%h wd=%h rd=%h, need pw=%b en=%b s1=%b s2=%b addr=%h wd=%h rd=%h",
                     name,
                     act.pwrite, act.penable, act.psel1, act.psel2,
                     act.paddr, act.pwdata, act.rdata,
                     exp.pwrite, exp.penable, exp.psel1, exp.psel2,
                     exp.paddr, exp.pwdata, exp.rdata);
        end else begin
            $display("ok   %s: pw=%b en=%b s1=%b s2=%b addr=%h wd=%h rd=%h",
                     name,
                     act.pwrite, act.penable, act.psel1, act.psel2,
                     act.paddr, act.pwdata, act.rdata);
        end
    endtask

    initial begin
        out_t zero;
        logic ds1;
        logic ds2;

        zero = mko(0, 0, 0, 0, '0, '0, '0);
        ds1  = ~SEL2;
        ds2  = SEL2;

        // Single write
        vecs[0]  = mkv(1, 0, 1, 32'h0, 32'h12153524, 32'h0, 32'h0,
                       mko(1, 0, 1, 0, 32'h0, 32'h12153524, 32'h0));
        vecs[1]  = mkv(0, 0, 1, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0,
                       mko(1, 1, 1, 0, 32'h0, 32'h12153524, 32'h0));
        vecs[2]  = mkv(0, 0, 1, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0,
                       mko(1, 0, 0, 0, 32'h0, 32'h12153524, 32'h0));

        // Single read
        vecs[3]  = mkv(1, 1, 1, 32'h0, 32'h0, 32'h1, 32'hC0895E81,
                       mko(0, 0, 1, 0, 32'h1, 32'h12153524, 32'h0));
        vecs[4]  = mkv(0, 1, 1, 32'h0, 32'h0, 32'h1, 32'hC0895E81,
                       mko(0, 1, 1, 0, 32'h1, 32'h12153524, 32'h0));
        vecs[5]  = mkv(0, 1, 1, 32'h0, 32'h0, 32'h1, 32'hC0895E81,
                       mko(0, 0, 0, 0, 32'h1, 32'h12153524, 32'hC0895E81));

        // Read with three wait states; the inputs change mid-transfer
        vecs[6]  = mkv(1, 1, 0, 32'h0, 32'h0, 32'h10, 32'h11111111,
                       mko(0, 0, 1, 0, 32'h10, 32'h12153524, 32'hC0895E81));
        vecs[7]  = mkv(0, 0, 0, 32'h30, 32'h33333333, 32'h20, 32'h22222222,
                       mko(0, 1, 1, 0, 32'h10, 32'h12153524, 32'hC0895E81));
        vecs[8]  = mkv(0, 0, 0, 32'h30, 32'h33333333, 32'h20, 32'h22222222,
                       mko(0, 1, 1, 0, 32'h10, 32'h12153524, 32'hC0895E81));
        vecs[9]  = mkv(0, 1, 0, 32'h30, 32'h33333333, 32'h20, 32'h44444444,
                       mko(0, 1, 1, 0, 32'h10, 32'h12153524, 32'hC0895E81));
        vecs[10] = mkv(0, 1, 0, 32'h30, 32'h33333333, 32'h20, 32'h55555555,
                       mko(0, 1, 1, 0, 32'h10, 32'h12153524, 32'hC0895E81));
        vecs[11] = mkv(0, 1, 1, 32'h30, 32'h33333333, 32'h20, 32'hA5A5A5A5,
                       mko(0, 0, 0, 0, 32'h10, 32'h12153524, 32'hA5A5A5A5));

        // Back-to-back: write, read, write with transfer held high
        vecs[12] = mkv(1, 0, 1, 32'h44, 32'h0BADF00D, 32'h48, 32'h0,
                       mko(1, 0, 1, 0, 32'h44, 32'h0BADF00D, 32'hA5A5A5A5));
        vecs[13] = mkv(1, 1, 1, 32'h44, 32'h0BADF00D, 32'h48, 32'h99999999,
                       mko(1, 1, 1, 0, 32'h44, 32'h0BADF00D, 32'hA5A5A5A5));
        vecs[14] = mkv(1, 1, 1, 32'h44, 32'h0BADF00D, 32'h48, 32'h99999999,
                       mko(0, 0, 1, 0, 32'h48, 32'h0BADF00D, 32'hA5A5A5A5));
        vecs[15] = mkv(1, 0, 1, 32'h4C, 32'hCAFEBABE, 32'h48, 32'h5EEDC0DE,
                       mko(0, 1, 1, 0, 32'h48, 32'h0BADF00D, 32'hA5A5A5A5));
        vecs[16] = mkv(1, 0, 1, 32'h4C, 32'hCAFEBABE, 32'h48, 32'h5EEDC0DE,
                       mko(1, 0, 1, 0, 32'h4C, 32'hCAFEBABE, 32'h5EEDC0DE));
        vecs[17] = mkv(0, 0, 1, 32'h4C, 32'hCAFEBABE, 32'h48, 32'h0,
                       mko(1, 1, 1, 0, 32'h4C, 32'hCAFEBABE, 32'h5EEDC0DE));
        vecs[18] = mkv(0, 0, 1, 32'h4C, 32'hCAFEBABE, 32'h48, 32'h0,
                       mko(1, 0, 0, 0, 32'h4C, 32'hCAFEBABE, 32'h5EEDC0DE));

        // Slave decode on the address MSB
        vecs[19] = mkv(1, 1, 1, 32'h0, 32'h0, 32'h80000004, 32'h76543210,
                       mko(0, 0, ds1, ds2, 32'h80000004, 32'hCAFEBABE,
                           32'h5EEDC0DE));
        vecs[20] = mkv(0, 1, 1, 32'h0, 32'h0, 32'h80000004, 32'h76543210,
                       mko(0, 1, ds1, ds2, 32'h80000004, 32'hCAFEBABE,
                           32'h5EEDC0DE));
        vecs[21] = mkv(0, 1, 1, 32'h0, 32'h0, 32'h80000004, 32'h76543210,
                       mko(0, 0, 0, 0, 32'h80000004, 32'hCAFEBABE,
                           32'h76543210));

        // Reset state
        PRESETn         = 1'b1;
        transfer        = 1'b0;
        READ_WRITE      = 1'b0;
        PREADY          = 1'b0;
        apb_write_paddr = '0;
        apb_write_data  = '0;
        apb_read_paddr  = '0;
        PRDATA          = '0;
        repeat (2) @(posedge PCLK);
        #1;
        check("reset", sample(), zero);
        @(negedge PCLK);
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1;
        check("idle_after_reset", sample(), zero);

        // Table
        for (int i = 0; i < NV; i++) begin
            @(negedge PCLK);
            transfer        = vecs[i].tr;
            READ_WRITE      = vecs[i].rw;
            PREADY          = vecs[i].rdy;
            apb_write_paddr = vecs[i].wpa;
            apb_write_data  = vecs[i].wd;
            apb_read_paddr  = vecs[i].rpa;
            PRDATA          = vecs[i].prd;
            @(posedge PCLK);
            #1;
            check($sformatf("vec%0d", i), sample(), vecs[i].exp);
        end

        // Asynchronous reset in the middle of a read wait state
        @(negedge PCLK);
        transfer       = 1'b1;
        READ_WRITE     = 1'b1;
        PREADY         = 1'b0;
        apb_read_paddr = 32'h8;
        PRDATA         = 32'hFFFFFFFF;
        @(posedge PCLK);                    // enters SETUP
        @(negedge PCLK);
        transfer = 1'b0;
        @(posedge PCLK);                    // enters ACCESS
        #1;
        check("pre_abort_access", sample(),
              mko(0, 1, 1, 0, 32'h8, 32'hCAFEBABE, 32'h76543210));
        #2;
        PRESETn = 1'b1;                     // no clock edge here
        #1;
        check("async_abort", sample(), zero);
        PREADY = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1;
        check("post_abort_idle", sample(), zero);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, need finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB (AMBA 3) bus master bridging a simple request interface (transfer strobe, read/write select, separate read/write addresses and write data) onto an APB bus with two slave selects. It sits between a host-side controller or testbench and APB peripherals such as GPIO (slave 1) and UART (slave 2). It runs the standard IDLE/SETUP/ACCESS protocol, honours PREADY wait states and returns captured read data.

## Interface
- DATA_WIDTH, 32, width of PWDATA/PRDATA/read-data bus
- ADDRESS_WIDTH, 32, width of request addresses and PADDR
- PCLK  in  1  bus clock; all state changes on rising edge
- PRESETn  in  1  asynchronous, active-high reset
- transfer  in  1  request strobe; high = perform/continue transfers
- READ_WRITE  in  1  1 = read, 0 = write; sampled with transfer
- PREADY  in  1  slave ready; completes ACCESS phase
- apb_write_paddr  in  ADDRESS_WIDTH  write target address
- apb_write_data  in  DATA_WIDTH  write data
- apb_read_paddr  in  ADDRESS_WIDTH  read target address
- PRDATA  in  DATA_WIDTH  slave read data
- PWRITE  out  1  APB direction, 1 = write
- PENABLE  out  1  APB enable (ACCESS phase)
- PSEL1  out  1  select for slave 1
- PSEL2  out  1  select for slave 2
- PADDR  out  ADDRESS_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- apb_read_data_out  out  DATA_WIDTH  last completed read data

## Operation
- States: IDLE, SETUP, ACCESS (2-bit encoded).
- IDLE: PSEL1=PSEL2=0, PENABLE=0. transfer=1 -> SETUP.
- SETUP: selected PSELx=1, PENABLE=0. Unconditionally -> ACCESS.
- ACCESS: selected PSELx=1, PENABLE=1. PREADY=0 -> stay (wait state). PREADY=1: transfer=1 -> SETUP (back-to-back), transfer=0 -> IDLE.
- Request latch on every entry to SETUP: PWRITE <= ~READ_WRITE; PADDR <= READ_WRITE ? apb_read_paddr : apb_write_paddr; PWDATA <= apb_write_data for writes (unchanged on reads). Held stable through SETUP and ACCESS, including wait states; inputs changing mid-transfer have no effect.
- Slave decode from latched PADDR[ADDRESS_WIDTH-1]: 0 -> PSEL1, 1 -> PSEL2. Exactly one PSEL high outside IDLE.
- Read capture: in ACCESS with PREADY=1 and PWRITE=0, apb_read_data_out <= PRDATA. Holds until next completed read; writes never modify it.
- Reset (async, PRESETn=1): state IDLE; PWRITE, PENABLE, PSEL1, PSEL2, PADDR, PWDATA, apb_read_data_out all 0. Reset mid-transfer aborts immediately, no completion, no read capture.
- No error (PSLVERR) handling; no timeout on PREADY.

## Timing
- transfer sampled at edge N (in IDLE) -> SETUP visible after N; ACCESS after N+1; with PREADY=1 during ACCESS, completion and read capture at edge N+2; apb_read_data_out valid after N+2.
- Each wait cycle (PREADY=0 in ACCESS) adds one cycle.
- Back-to-back: completion edge re-enters SETUP, 2 cycles per transfer with zero waits; new request fields sampled at that completion edge.
- PSELx/PENABLE decoded from registered state (glitch-free, no combinational path from inputs).

## Configuration
- APB_MASTER_SEL2_EN defined: two-slave decode as above.
- Not defined: PSEL2 tied 0; every transfer selects PSEL1 regardless of PADDR[ADDRESS_WIDTH-1]; PADDR still carries the full address.

## Test plan
- Reset: assert PRESETn mid-ACCESS -> all outputs 0, state IDLE within same cycle (async), apb_read_data_out=0.
- Write: transfer=1, READ_WRITE=0, write_paddr=0x0, data=0x12153524, PREADY=1 -> PSEL1=1, PWRITE=1, PADDR=0, PWDATA=0x12153524 for 2 cycles, PENABLE only in second; apb_read_data_out unchanged.
- Read: READ_WRITE=1, read_paddr=0x1, PRDATA=0xC0895E81 -> PWRITE=0, PADDR=1, apb_read_data_out=0xC0895E81 after 3rd edge.
- Wait states: PREADY low 3 ACCESS cycles -> PENABLE held 4 cycles, PADDR/PWDATA stable, capture only when PREADY=1.
- Decode: read_paddr=0x8000_0004 -> PSEL2=1, PSEL1=0 (macro defined); PSEL1=1, PSEL2=0 (undefined).
- Back-to-back: transfer held high, alternating write/read -> SETUP/ACCESS repeat with no IDLE cycle; transfer dropped -> IDLE after completion.
